// File: rtl/imem_loader.sv
// Byte-stream loader: parses A5-framed records into instruction-buffer line writes,
// holding the processor in reset while a frame is in flight.
module imem_loader #(
  parameter int i_adr_width   = 10,
  parameter int i_width       = 20,
  parameter int i_buffer_size = 2
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [7:0]                         in_data,
  input  logic                               in_valid,
  output logic                               in_ready,
  output logic [i_adr_width-1:0]             imem_write_adr,
  output logic                               imem_write,
  output logic [i_buffer_size*i_width-1:0]   imem_in,
  output logic                               pat_hold,
  output logic                               load_done,
  output logic                               load_err
);
  localparam int LW = i_buffer_size * i_width;
  localparam int LB = (LW + 7) / 8;
  localparam int KW = (LB > 1) ? $clog2(LB) : 1;
  localparam logic [7:0]             SYNC    = 8'hA5;
  localparam logic [i_adr_width-1:0] ADR_ONE = i_adr_width'(1);
  localparam logic [KW-1:0]          K_ONE   = KW'(1);
  localparam logic [KW-1:0]          K_LAST  = KW'(LB - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADR0, S_ADR1, S_CNT0, S_CNT1, S_DATA, S_WRITE, S_CHK
  } state_t;

  state_t                  state_q, state_d;
  logic [i_adr_width-1:0]  adr_q, adr_d;
  logic [i_adr_width-1:0]  cnt_q, cnt_d;
  logic [KW-1:0]           k_q, k_d;
  logic [7:0]              lo_q, lo_d;
  logic [7:0]              chk_q, chk_d;
  logic [LB*8-1:0]         line_q, line_d;
  logic [i_adr_width-1:0]  wadr_q, wadr_d;
  logic [LW-1:0]           win_q, win_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic                    acc;

  assign in_ready       = ~reset && (state_q != S_WRITE);
  assign acc            = in_valid && in_ready;
  assign imem_write     = (state_q == S_WRITE);
  assign imem_write_adr = wadr_q;
  assign imem_in        = win_q;
  assign pat_hold       = (state_q != S_IDLE);
  assign load_done      = done_q;
  assign load_err       = err_q;

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    lo_d    = lo_q;
    chk_d   = chk_q;
    line_d  = line_q;
    wadr_d  = wadr_q;
    win_d   = win_q;
    done_d  = 1'b0;
    err_d   = err_q;
    case (state_q)
      S_IDLE: if (acc) begin
        if (in_data == SYNC) begin
          state_d = S_ADR0;
          err_d   = 1'b0;
          chk_d   = 8'h00;
          k_d     = '0;
        end else begin
          err_d = 1'b1;
        end
      end
      S_ADR0: if (acc) begin
        lo_d    = in_data;
        chk_d   = chk_q ^ in_data;
        state_d = S_ADR1;
      end
      S_ADR1: if (acc) begin
        adr_d   = i_adr_width'({in_data, lo_q});
        chk_d   = chk_q ^ in_data;
        state_d = S_CNT0;
      end
      S_CNT0: if (acc) begin
        lo_d    = in_data;
        chk_d   = chk_q ^ in_data;
        state_d = S_CNT1;
      end
      S_CNT1: if (acc) begin
        cnt_d   = i_adr_width'({in_data, lo_q});
        chk_d   = chk_q ^ in_data;
        state_d = S_DATA;
      end
      S_DATA: if (acc) begin
        chk_d = chk_q ^ in_data;
        for (int i = 0; i < LB; i++) begin
          if (k_q == KW'(i)) line_d[i*8 +: 8] = in_data;
        end
        if (k_q == K_LAST) begin
          // Capture the finished line so the outputs are stable through WRITE and after.
          k_d     = '0;
          win_d   = line_d[LW-1:0];
          wadr_d  = adr_q;
          state_d = S_WRITE;
        end else begin
          k_d = k_q + K_ONE;
        end
      end
      S_WRITE: begin
        adr_d = adr_q + ADR_ONE;
        if (cnt_q == '0) begin
          state_d = S_CHK;
        end else begin
          cnt_d   = cnt_q - ADR_ONE;
          state_d = S_DATA;
        end
      end
      S_CHK: if (acc) begin
        if (in_data == chk_q) done_d = 1'b1;
        else                  err_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      adr_q   <= '0;
      cnt_q   <= '0;
      k_q     <= '0;
      lo_q    <= '0;
      chk_q   <= '0;
      line_q  <= '0;
      wadr_q  <= '0;
      win_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      lo_q    <= lo_d;
      chk_q   <= chk_d;
      line_q  <= line_d;
      wadr_q  <= wadr_d;
      win_q   <= win_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: frames are driven byte by byte, expected line
// writes are queued and a negedge monitor pops and compares them.
module tb_imem_loader;
  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  imem_write_adr;
  logic        imem_write;
  logic [39:0] imem_in;
  logic        pat_hold;
  logic        load_done;
  logic        load_err;

  imem_loader dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .imem_write_adr(imem_write_adr), .imem_write(imem_write),
    .imem_in(imem_in), .pat_hold(pat_hold), .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  adr;
    logic [39:0] dat;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mon_e;
  logic [39:0] lines_mem [0:3];
  int          total = 0;
  int          bad = 0;
  int          done_cnt = 0;
  int          ready_low_cnt = 0;
  int          done_start, rl_start;
  bit          gap = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (!in_ready) ready_low_cnt++;
      if (load_done) begin
        done_cnt++;
        chk("pat_hold_at_done", {63'b0, pat_hold}, 64'd0);
      end
    end
    if (imem_write) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got adr=%0h data=%0h want none", imem_write_adr, imem_in);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_adr", {54'b0, imem_write_adr}, {54'b0, mon_e.adr});
        chk("wr_data", {24'b0, imem_in}, {24'b0, mon_e.dat});
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    if (gap) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("send_timeout", 64'd1, 64'd0);
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // abort_at >= 0 stops after that many data bytes, leaving the frame open.
  task automatic send_frame(input logic [9:0] adr, input int nlines,
                            input logic [7:0] chk_flip, input int abort_at);
    logic [7:0] c;
    logic [9:0] cnt;
    logic [9:0] a;
    logic [7:0] b;
    int         sent = 0;
    done_start = done_cnt;
    rl_start   = ready_low_cnt;
    cnt = 10'(nlines - 1);
    c = 8'h00;
    send_byte(8'hA5);
    #1;
    chk("pat_hold_after_sync", {63'b0, pat_hold}, 64'd1);
    chk("err_clear_on_sync", {63'b0, load_err}, 64'd0);
    b = adr[7:0];          c ^= b; send_byte(b);
    b = {6'b0, adr[9:8]};  c ^= b; send_byte(b);
    b = cnt[7:0];          c ^= b; send_byte(b);
    b = {6'b0, cnt[9:8]};  c ^= b; send_byte(b);
    for (int l = 0; l < nlines; l++) begin
      a = adr + 10'(l);
      if (abort_at < 0 || (l + 1) * 5 <= abort_at)
        exp_q.push_back('{adr: a, dat: lines_mem[l]});
      for (int k = 0; k < 5; k++) begin
        if (abort_at >= 0 && sent == abort_at) return;
        b = lines_mem[l][8*k +: 8];
        c ^= b;
        send_byte(b);
        sent++;
      end
    end
    send_byte(c ^ chk_flip);
    idle(1);
  endtask

  task automatic finish_frame(input string tag, input int exp_done, input bit exp_err,
                              input int exp_rl);
    idle(4);
    chk({tag, "_done"}, 64'(done_cnt - done_start), 64'(exp_done));
    chk({tag, "_err"}, {63'b0, load_err}, {63'b0, exp_err});
    chk({tag, "_ready_low"}, 64'(ready_low_cnt - rl_start), 64'(exp_rl));
    chk({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
    chk({tag, "_pat_hold"}, {63'b0, pat_hold}, 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, {63'b0, in_ready}, 64'd0);
    chk({tag, "_write"}, {63'b0, imem_write}, 64'd0);
    chk({tag, "_adr"}, {54'b0, imem_write_adr}, 64'd0);
    chk({tag, "_imem_in"}, {24'b0, imem_in}, 64'd0);
    chk({tag, "_pat_hold"}, {63'b0, pat_hold}, 64'd0);
    chk({tag, "_done"}, {63'b0, load_done}, 64'd0);
    chk({tag, "_err"}, {63'b0, load_err}, 64'd0);
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("ready_after_reset", {63'b0, in_ready}, 64'd1);

    // Single line at 0x010; checksum works out to 0x01.
    lines_mem[0] = 40'h55_44_33_22_11;
    send_frame(10'h010, 1, 8'h00, -1);
    finish_frame("basic", 1, 1'b0, 1);
    chk("basic_held_adr", {54'b0, imem_write_adr}, 64'h010);
    chk("basic_held_data", {24'b0, imem_in}, 64'h55_4433_2211);

    // Address wrap 0x3FF -> 0x000.
    lines_mem[0] = 40'hA1_B2_C3_D4_E5;
    lines_mem[1] = 40'h0F_1E_2D_3C_4B;
    send_frame(10'h3FF, 2, 8'h00, -1);
    finish_frame("wrap", 1, 1'b0, 2);

    // Bad checksum: write still happens, error stays sticky.
    lines_mem[0] = 40'h55_44_33_22_11;
    send_frame(10'h010, 1, 8'h01, -1);
    finish_frame("badchk", 0, 1'b1, 1);
    idle(5);
    chk("badchk_sticky", {63'b0, load_err}, 64'd1);

    // Same frame with in_valid toggling every cycle.
    gap = 1'b1;
    send_frame(10'h010, 1, 8'h00, -1);
    gap = 1'b0;
    finish_frame("toggle", 1, 1'b0, 1);

    // Stray byte in IDLE, then a good frame.
    send_byte(8'h5A);
    idle(2);
    chk("stray_err", {63'b0, load_err}, 64'd1);
    chk("stray_pat_hold", {63'b0, pat_hold}, 64'd0);
    send_frame(10'h010, 1, 8'h00, -1);
    finish_frame("recover", 1, 1'b0, 1);

    // Reset after the third data byte of line 2 of a 3-line frame.
    lines_mem[0] = 40'h12_34_56_78_9A;
    lines_mem[1] = 40'hDE_AD_BE_EF_01;
    lines_mem[2] = 40'hCA_FE_F0_0D_77;
    send_frame(10'h100, 3, 8'h00, 8);
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("abort");
    chk("abort_pending", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    idle(6);
    chk("abort_no_done", 64'(done_cnt - done_start), 64'd0);
    chk("abort_pat_hold", {63'b0, pat_hold}, 64'd0);
    chk("abort_ready", {63'b0, in_ready}, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The module SHALL have parameters: i_adr_width, default 10, instruction-buffer address width.
REQ-002 The module SHALL have parameters: i_width, default 20, one instruction width.
REQ-003 The module SHALL have parameters: i_buffer_size, default 2, instructions per buffer line.
REQ-004 The module SHALL have ports:
- clk  input  1  sole clock; all logic on rising edge.
- reset  input  1  synchronous, active-high.
- in_data  input  8  loader byte stream.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader accepts the byte this cycle.
- imem_write_adr  output  i_adr_width  buffer line address.
- imem_write  output  1  one-cycle write strobe to the instruction buffer.
- imem_in  output  i_buffer_size*i_width  assembled line (40 bits at defaults).
- pat_hold  output  1  holds the processor in reset while loading.
- load_done  output  1  one-cycle pulse on good completion.
- load_err  output  1  sticky checksum or sync error.

Function
REQ-005 A byte SHALL be accepted only on a cycle where in_valid and in_ready are both 1; no other cycle SHALL change the state.
REQ-006 The frame format SHALL be sync 0xA5, ADR_LO, ADR_HI, CNT_LO, CNT_HI, then (CNT+1) lines of L = ceil(i_buffer_size*i_width/8) bytes (5 at defaults), then one CHK byte.
REQ-007 The start address SHALL be {ADR_HI,ADR_LO}[i_adr_width-1:0]. The line count SHALL be {CNT_HI,CNT_LO}[i_adr_width-1:0]+1, i.e. 1..1024 lines.
REQ-008 The FSM states SHALL be IDLE, ADR0, ADR1, CNT0, CNT1, DATA, WRITE, CHK.
- IDLE goes to ADR0 on an accepted 0xA5.
- An accepted non-0xA5 byte in IDLE SHALL be discarded and SHALL set load_err.
- ADR0, ADR1, CNT0 and CNT1 each advance on one accepted byte.
- CNT1 goes to DATA.
REQ-009 In DATA, line bytes SHALL be packed little-endian: the k-th byte (k=0..L-1) goes to imem_in[8k+7:8k]; bits beyond the line width are discarded.
REQ-010 On acceptance of byte L-1, the FSM SHALL enter WRITE. For exactly one cycle in WRITE:
- imem_write=1;
- imem_write_adr = current address;
- imem_in = the assembled line.
REQ-011 in_ready SHALL be 0 in WRITE and 1 in all other states when not in reset.
REQ-012 After WRITE, the address SHALL increment modulo 2^i_adr_width (0x3FF wraps to 0x000). The remaining-line counter SHALL decrement; the FSM goes to DATA if lines remain, else to CHK.
REQ-013 imem_in and imem_write_adr SHALL hold their last values when imem_write=0.
REQ-014 The checksum SHALL be the 8-bit XOR of all accepted bytes from ADR_LO through the last data byte.
- In CHK, one accepted byte that equals the checksum SHALL pulse load_done for one cycle.
- A byte that does not equal the checksum SHALL set load_err.
- In both cases the FSM returns to IDLE.
REQ-015 pat_hold SHALL be 1 in every state except IDLE. It SHALL fall on the cycle load_done pulses or the error return to IDLE occurs.
REQ-016 load_err SHALL be cleared by reset or by acceptance of a new 0xA5 in IDLE.
REQ-017 At most one imem_write SHALL occur per line, and writes SHALL never occur outside WRITE.

Reset
REQ-018 While reset=1 at a clock edge, the following SHALL hold on the next cycle:
- state=IDLE;
- in_ready=0 during reset, 1 after;
- imem_write=0, imem_write_adr=0, imem_in=0;
- pat_hold=0, load_done=0, load_err=0;
- counters and checksum = 0.
REQ-019 Reset mid-frame SHALL abort the frame with no further write. Lines already written SHALL stay in the buffer.

Verification
REQ-020 Frame A5 10 00 00 00 | 11 22 33 44 55 | CHK=0x10^0x11^0x22^0x33^0x44^0x55 -> exactly one write, adr=0x010, imem_in=0x5544332211; load_done pulse; pat_hold 1 from sync+1 until done.
REQ-021 Frame with start 0x3FF, CNT=1 (2 lines) -> writes at 0x3FF then 0x000; in_ready low only in the two WRITE cycles.
REQ-022 Same as REQ-020 with CHK xor 0x01 -> write still occurs; no load_done; load_err=1 and stays 1 until the next 0xA5.
REQ-023 in_valid toggled 1/0 every cycle during REQ-020 -> identical write content and address; no byte lost or duplicated.
REQ-024 Reset asserted after the 3rd data byte of line 2 in a 3-line frame -> line 1 written, no further imem_write, all outputs at reset values.
REQ-025 Byte 0x5A in IDLE, then a valid REQ-020 frame -> load_err set, then cleared by 0xA5; normal load completes.
